reload_fifo_ctrl: RTL and testbench

Controller that owns one `reload_fifo` instance: it round-robin arbitrates NUM_REQ write requesters onto the FIFO write port and sequences length-counted read bursts toward one consumer. It also issues FIFO flushes. It sits between the tour-generation producers and the reload consumer, and is the only block allowed to drive the FIFO's wren/rden/reset pins.

---
 rtl/reload_pkg.sv | 5 +
 rtl/reload_skid_buf.sv | 33 +++
 rtl/reload_fifo_ctrl.sv | 123 ++++++++++++
 tb/tb_reload_fifo_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reload_pkg.sv
// reload_pkg: shared read-FSM state encoding and skid depth for the reload FIFO controller
package reload_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, FLUSH = 2'd3} reload_ctrl_state_t;
  localparam int RELOAD_SKID_DEPTH = 2;
endpackage

// File: rtl/reload_skid_buf.sv
// reload_skid_buf: two-entry valid/ready buffer with synchronous clear
module reload_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   cnt
);
  logic [W-1:0] d1;
  logic         pop;
  logic [1:0]   wr_idx;
  assign out_valid = cnt != 2'd0;
  assign pop       = out_valid && out_ready;
  assign wr_idx    = cnt - {1'b0, pop};
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      cnt      <= 2'd0;
      out_data <= '0;
      d1       <= '0;
    end else begin
      if (pop) out_data <= d1;
      if (in_valid && wr_idx == 2'd0) out_data <= in_data;
      if (in_valid && wr_idx == 2'd1) d1 <= in_data;
      cnt <= cnt + {1'b0, in_valid} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/reload_fifo_ctrl.sv
// reload_fifo_ctrl: round-robin FIFO write arbiter and length-counted read burst sequencer (stat counters built only with RELOAD_FIFO_CTRL_STATS_EN)
module reload_fifo_ctrl
  import reload_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 32,
  parameter int MAX_BURST  = 256,
  parameter int LEN_W      = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          burst_start,
  input  logic [LEN_W-1:0]              burst_len,
  output logic [FIFO_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          burst_busy,
  output logic                          burst_done,
  output logic                          burst_abort,
  input  logic                          flush,
  output logic [FIFO_WIDTH-1:0]         fifo_wrdata,
  output logic                          fifo_wren,
  output logic                          fifo_rden,
  output logic                          fifo_wr_reset,
  output logic                          fifo_rd_reset,
  input  logic [FIFO_WIDTH-1:0]         fifo_rddata,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  input  logic                          fifo_empty,
  output logic [31:0]                   stat_wr_cnt,
  output logic [31:0]                   stat_rd_cnt
);
  localparam int IW = $clog2(NUM_REQ);
  reload_ctrl_state_t state;
  logic [IW-1:0]    last, win, j;
  logic             hit, xfer, in_flight, abort_r, hs, last_word;
  logic [LEN_W-1:0] rem, norm_len;
  logic [1:0]       skid_cnt, cred;
  always_comb begin
    win = last;
    hit = 1'b0;
    j   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = IW'((int'(last) + k) % NUM_REQ);
      if (req_valid[j]) begin
        win = j;
        hit = 1'b1;
      end
    end
  end
  assign xfer = reset_n && hit && !fifo_full && !(fifo_almost_full && fifo_wren) && state != FLUSH && !flush;
  assign req_ready = xfer ? NUM_REQ'(1) << win : '0;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last        <= IW'(NUM_REQ - 1);
      fifo_wren   <= 1'b0;
      fifo_wrdata <= '0;
    end else begin
      fifo_wren <= xfer;
      if (xfer) begin
        last        <= win;
        fifo_wrdata <= req_data[win*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end
  assign norm_len = burst_len == '0 ? LEN_W'(1) : burst_len > LEN_W'(MAX_BURST) ? LEN_W'(MAX_BURST) : burst_len;
  assign hs        = out_valid && out_ready;
  assign cred      = skid_cnt + {1'b0, in_flight} - {1'b0, hs};
  assign fifo_rden = reset_n && !flush && state == RUN && !fifo_empty && cred < 2'(RELOAD_SKID_DEPTH);
  assign last_word = state == DRAIN && !in_flight && (skid_cnt == 2'd0 || (skid_cnt == 2'd1 && hs));
  assign burst_busy    = state == RUN || state == DRAIN;
  assign burst_abort   = reset_n && state == FLUSH && abort_r;
  assign burst_done    = reset_n && (burst_abort || (last_word && !flush));
  assign fifo_wr_reset = !reset_n || state == FLUSH;
  assign fifo_rd_reset = !reset_n || state == FLUSH;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      rem       <= '0;
      in_flight <= 1'b0;
      abort_r   <= 1'b0;
    end else begin
      in_flight <= fifo_rden;
      abort_r   <= flush && (state == RUN || state == DRAIN);
      rem       <= state == IDLE && burst_start ? norm_len : fifo_rden ? rem - LEN_W'(1) : rem;
      state     <= flush ? FLUSH :
                   state == IDLE && burst_start ? RUN :
                   state == RUN && fifo_rden && rem == LEN_W'(1) ? DRAIN :
                   state == FLUSH || last_word ? IDLE : state;
    end
  end
  reload_skid_buf #(.W(FIFO_WIDTH)) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (flush || state == FLUSH),
    .in_valid  (in_flight),
    .in_data   (fifo_rddata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .cnt       (skid_cnt)
  );
`ifdef RELOAD_FIFO_CTRL_STATS_EN
  logic [31:0] wr_cnt, rd_cnt;
  always_ff @(posedge clk) begin
    if (!reset_n || state == FLUSH) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (fifo_wren) wr_cnt <= wr_cnt + 32'd1;
      if (hs) rd_cnt <= rd_cnt + 32'd1;
    end
  end
  assign stat_wr_cnt = wr_cnt;
  assign stat_rd_cnt = rd_cnt;
`else
  assign stat_wr_cnt = '0;
  assign stat_rd_cnt = '0;
`endif
endmodule

// File: tb/tb_reload_fifo_ctrl.sv
// tb_reload_fifo_ctrl: directed self-checking bench for reload_fifo_ctrl with a behavioural FIFO
module tb_reload_fifo_ctrl;
  localparam int NR = 4, W = 32, MB = 256, LW = $clog2(MB + 1), DEPTH = 16;
  typedef struct packed {
    logic [3:0] v;
    logic [3:0] r;
  } arb_t;
  logic clk = 1'b0;
  logic reset_n, flush, burst_start, out_ready, pre_en, push;
  logic [NR-1:0] req_valid, req_ready;
  logic [NR*W-1:0] req_data;
  logic [LW-1:0] burst_len;
  logic [W-1:0] out_data, fifo_wrdata, pre_data;
  logic [W-1:0] fifo_rddata = '0;
  logic out_valid, burst_busy, burst_done, burst_abort;
  logic fifo_wren, fifo_rden, fifo_wr_reset, fifo_rd_reset;
  logic fifo_full, fifo_almost_full, fifo_empty;
  logic [31:0] stat_wr_cnt, stat_rd_cnt;
  logic [W-1:0] mem [DEPTH];
  int rp = 0, wp = 0, fcnt = 0;
  int n_chk = 0, n_fail = 0;
  arb_t tbl [10];
  always #5 clk = ~clk;
  reload_fifo_ctrl #(.NUM_REQ(NR), .FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .burst_start      (burst_start),
    .burst_len        (burst_len),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .burst_busy       (burst_busy),
    .burst_done       (burst_done),
    .burst_abort      (burst_abort),
    .flush            (flush),
    .fifo_wrdata      (fifo_wrdata),
    .fifo_wren        (fifo_wren),
    .fifo_rden        (fifo_rden),
    .fifo_wr_reset    (fifo_wr_reset),
    .fifo_rd_reset    (fifo_rd_reset),
    .fifo_rddata      (fifo_rddata),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .fifo_empty       (fifo_empty),
    .stat_wr_cnt      (stat_wr_cnt),
    .stat_rd_cnt      (stat_rd_cnt)
  );
  assign push             = fifo_wren || pre_en;
  assign fifo_full        = fcnt >= DEPTH;
  assign fifo_almost_full = fcnt >= DEPTH - 1;
  assign fifo_empty       = fcnt == 0;
  always @(posedge clk) begin
    if (fifo_wr_reset) begin
      rp   <= 0;
      wp   <= 0;
      fcnt <= 0;
    end else begin
      if (fifo_rden) begin
        fifo_rddata <= mem[rp];
        rp <= (rp + 1) % DEPTH;
      end
      if (push) begin
        mem[wp] <= fifo_wren ? fifo_wrdata : pre_data;
        wp <= (wp + 1) % DEPTH;
      end
      fcnt <= fcnt + (push ? 1 : 0) - (fifo_rden ? 1 : 0);
    end
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #2;
  endtask
  task automatic preload(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      pre_data = W'(base + i);
      pre_en   = 1'b1;
      nxt();
    end
    pre_en = 1'b0;
  endtask
  task automatic flush_fifo;
    flush = 1'b1;
    nxt();
    flush = 1'b0;
    nxt();
  endtask
  function automatic int oh(input logic [3:0] r);
    int k;
    k = 0;
    for (int i = 0; i < 4; i++) if (r[i]) k = i;
    return k;
  endfunction
  task automatic run_burst(input int len, input bit tog, input int nexp);
    int got, dones, pops, hsn, maxo, first, lastc;
    got = 0; dones = 0; pops = 0; hsn = 0; maxo = 0; first = 0; lastc = 0;
    burst_len   = LW'(len);
    burst_start = 1'b1;
    nxt();
    burst_start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      out_ready   = tog ? (c % 2 == 0) : 1'b1;
      burst_start = tog && c == 3;
      #1;
      if (pops - hsn > maxo) maxo = pops - hsn;
      if (fifo_rden) pops++;
      if (burst_done) dones++;
      if (out_valid && out_ready) begin
        check("burst_data", out_data, 32'(got + 1));
        check("done_on_last", 32'(burst_done), 32'(got + 1 == nexp));
        if (got == 0) first = c;
        lastc = c;
        got++;
        hsn++;
      end
      nxt();
    end
    burst_start = 1'b0;
    out_ready   = 1'b1;
    check("burst_words", got, nexp);
    check("done_count", dones, 1);
    check("busy_after", 32'(burst_busy), 0);
    if (tog) check("max_outstanding", 32'(maxo <= 2), 1);
    else check("back_to_back", lastc - first, nexp - 1);
  endtask
  initial begin
    int prev, grants, wrens, viol;
    bit seen;
    tbl = '{'{4'b0101, 4'b0001}, '{4'b0101, 4'b0100}, '{4'b0101, 4'b0001}, '{4'b0101, 4'b0100},
            '{4'b1111, 4'b1000}, '{4'b1111, 4'b0001}, '{4'b0110, 4'b0010}, '{4'b0000, 4'b0000},
            '{4'b1001, 4'b1000}, '{4'b0010, 4'b0010}};
    reset_n = 1'b0; req_valid = 4'b0101; flush = 1'b0; burst_start = 1'b0; burst_len = '0;
    out_ready = 1'b1; pre_en = 1'b0; pre_data = '0;
    for (int i = 0; i < NR; i++) req_data[i*W +: W] = 32'hA0 + 32'h10 * i;
    nxt();
    nxt();
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_wren", 32'(fifo_wren), 0);
    check("rst_wrdata", fifo_wrdata, 0);
    check("rst_rden", 32'(fifo_rden), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", 32'(burst_busy), 0);
    check("rst_done", 32'(burst_done), 0);
    check("rst_abort", 32'(burst_abort), 0);
    check("rst_wr_reset", 32'(fifo_wr_reset), 1);
    check("rst_rd_reset", 32'(fifo_rd_reset), 1);
    check("rst_stat_wr", stat_wr_cnt, 0);
    reset_n = 1'b1;
    req_valid = '0;
    nxt();
    prev = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].v;
      #1;
      check("arb_ready", 32'(req_ready), 32'(tbl[i].r));
      check("arb_wren", 32'(fifo_wren), 32'(prev != 0));
      if (prev != 0) check("arb_wrdata", fifo_wrdata, 32'hA0 + 32'(32'h10 * oh(4'(prev))));
      prev = int'(tbl[i].r);
      nxt();
    end
    req_valid = '0;
    #1;
    check("arb_last_wren", 32'(fifo_wren), 1);
    check("arb_last_wrdata", fifo_wrdata, 32'hB0);
    nxt();
    flush_fifo();
    check("flush_empties", 32'(fifo_empty), 1);
    preload(15, 'h100);
    check("af_flag", 32'(fifo_almost_full), 1);
    grants = 0; wrens = 0; viol = 0;
    req_valid = 4'b0010;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (req_ready != '0) grants++;
      if (fifo_wren) wrens++;
      if (fifo_wren && fifo_full) viol++;
      nxt();
    end
    #1;
    check("af_grants", grants, 1);
    check("af_wrens", wrens, 1);
    check("af_wren_while_full", viol, 0);
    check("af_full", 32'(fifo_full), 1);
    check("af_ready_low", 32'(req_ready), 0);
    req_valid = '0;
    nxt();
    flush_fifo();
    preload(8, 1);
    run_burst(5, 1'b0, 5);
    check("remain_after_burst", fcnt, 3);
    flush_fifo();
    preload(8, 1);
    run_burst(5, 1'b1, 5);
    check("remain_after_toggle", fcnt, 3);
    flush_fifo();
    preload(8, 1);
    burst_len = LW'(6);
    burst_start = 1'b1;
    nxt();
    burst_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (out_valid && out_data == 32'd3) begin
        flush = 1'b1;
        seen = 1'b1;
        break;
      end
      nxt();
    end
    check("abort_word3_seen", 32'(seen), 1);
    nxt();
    flush = 1'b0;
    #1;
    check("abort_wr_reset", 32'(fifo_wr_reset), 1);
    check("abort_rd_reset", 32'(fifo_rd_reset), 1);
    check("abort_done", 32'(burst_done), 1);
    check("abort_abort", 32'(burst_abort), 1);
    nxt();
    #1;
    check("abort_reset_one_cycle", 32'(fifo_wr_reset), 0);
    check("abort_done_one_cycle", 32'(burst_done), 0);
    check("abort_empty", 32'(fifo_empty), 1);
    check("abort_idle", 32'(burst_busy), 0);
    check("abort_out_valid", 32'(out_valid), 0);
    nxt();
    preload(3, 1);
    run_burst(0, 1'b0, 1);
    check("len0_remain", fcnt, 2);
`ifdef RELOAD_FIFO_CTRL_STATS_EN
    check("len0_stat_rd", stat_rd_cnt, 1);
`else
    check("len0_stat_rd", stat_rd_cnt, 0);
`endif
    check("len0_stat_wr", stat_wr_cnt, 0);
    burst_len = LW'(2);
    burst_start = 1'b1;
    out_ready = 1'b0;
    nxt();
    burst_start = 1'b0;
    nxt();
    nxt();
    nxt();
    #1;
    check("midrst_busy_before", 32'(burst_busy), 1);
    check("midrst_valid_before", 32'(out_valid), 1);
    reset_n = 1'b0;
    #1;
    check("midrst_no_done", 32'(burst_done), 0);
    check("midrst_rd_reset", 32'(fifo_rd_reset), 1);
    nxt();
    #1;
    check("midrst_busy", 32'(burst_busy), 0);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_done", 32'(burst_done), 0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    nxt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
